cache_line_fill_ctrl: RTL

- Miss-side controller for the I-cache. On a miss it fetches one 128-bit cache line from downstream memory as an AHB-Lite WRAP4 read burst of 32-bit beats, starting at the critical word.
- It sequences the downstream master interface: address/data phase pipelining, wait states and error responses.
- It assembles the four beats into a line and hands the line to the cache tag/data array. The critical word is forwarded early so the upstream handler can restart.

---
 rtl/cache_line_fill_ctrl_pkg.sv | 24 ++
 rtl/cache_line_fill_ctrl_wrap_addr_gen.sv | 16 +
 rtl/cache_line_fill_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/cache_line_fill_ctrl_pkg.sv
// rtl/cache_line_fill_ctrl_pkg.sv - shared AHB-Lite encodings and fill FSM state type
package cache_line_fill_ctrl_pkg;

    typedef enum logic [2:0] {
        BURST_SINGLE = 3'b000,
        BURST_WRAP4  = 3'b010
    } burst_type_t;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } trans_type_t;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        ERR1
    } fill_state_t;

endpackage

// File: rtl/cache_line_fill_ctrl_wrap_addr_gen.sv
// rtl/cache_line_fill_ctrl_wrap_addr_gen.sv - wrapping beat address and line word index
module cache_line_fill_ctrl_wrap_addr_gen #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-5:0] base,
    input  logic [1:0]        w0,
    input  logic [1:0]        beat,
    output logic [ADDR_W-1:0] addr,
    output logic [1:0]        word
);

    // 2-bit add keeps the burst inside its 16-byte line
    assign word = w0 + beat;
    assign addr = {base, word, 2'b00};

endmodule

// File: rtl/cache_line_fill_ctrl.sv
// rtl/cache_line_fill_ctrl.sv - I-cache miss line fill via AHB-Lite WRAP4 read burst
module cache_line_fill_ctrl
    import cache_line_fill_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LINE_W = 128
) (
    input  logic              hclk,
    input  logic              hrstn,
    input  logic              fill_req,
    input  logic [ADDR_W-1:0] fill_addr,
    output logic              fill_busy,
    output logic              fill_done,
    output logic              fill_err,
    output logic [LINE_W-1:0] fill_line,
    output logic              crit_valid,
    output logic [DATA_W-1:0] crit_data,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output logic [2:0]        hburst,
    output logic [2:0]        hsize,
    output logic              hwrite,
    input  logic              hready,
    input  logic [DATA_W-1:0] hrdata,
    input  logic              hresp
);

    localparam int BEATS = LINE_W / DATA_W;

    fill_state_t                    state_q, state_d;
    logic [1:0]                     acnt_q, acnt_d;
    logic [1:0]                     dcnt_q, dcnt_d;
    logic [1:0]                     w0_q, w0_d;
    logic [ADDR_W-5:0]              base_q, base_d;
    logic                           dph_q, dph_d;
    logic [BEATS-1:0][DATA_W-1:0]   asm_q, asm_d;
    logic [BEATS-1:0][DATA_W-1:0]   line_q, line_d;
    logic [ADDR_W-1:0]              haddr_q, haddr_d;
    trans_type_t                    htrans_q, htrans_d;
    burst_type_t                    hburst_q, hburst_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;
    logic                           err_q, err_d;
    logic                           cv_q, cv_d;
    logic [DATA_W-1:0]              cd_q, cd_d;

    logic                           end_burst;
    logic [ADDR_W-1:0]              next_addr;
    logic [1:0]                     dword;
    logic [1:0]                     unused_a_word;
    logic [ADDR_W-1:0]              unused_d_addr;
    logic [1:0]                     unused_addr_bits;

    assign unused_addr_bits = fill_addr[1:0];

    cache_line_fill_ctrl_wrap_addr_gen #(.ADDR_W(ADDR_W)) u_agen (
        .base (base_q),
        .w0   (w0_q),
        .beat (acnt_q + 2'd1),
        .addr (next_addr),
        .word (unused_a_word)
    );

    cache_line_fill_ctrl_wrap_addr_gen #(.ADDR_W(ADDR_W)) u_dgen (
        .base (base_q),
        .w0   (w0_q),
        .beat (dcnt_q),
        .addr (unused_d_addr),
        .word (dword)
    );

    always_comb begin
        state_d   = state_q;
        acnt_d    = acnt_q;
        dcnt_d    = dcnt_q;
        w0_d      = w0_q;
        base_d    = base_q;
        dph_d     = dph_q;
        asm_d     = asm_q;
        line_d    = line_q;
        haddr_d   = haddr_q;
        htrans_d  = htrans_q;
        hburst_d  = hburst_q;
        busy_d    = busy_q;
        cd_d      = cd_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        cv_d      = 1'b0;
        end_burst = 1'b0;

        case (state_q)
            IDLE: begin
                // the fill_done cycle itself never accepts a held request
                if (fill_req && !done_q) begin
                    base_d   = fill_addr[ADDR_W-1:4];
                    w0_d     = fill_addr[3:2];
                    acnt_d   = 2'd0;
                    dcnt_d   = 2'd0;
                    dph_d    = 1'b0;
                    haddr_d  = {fill_addr[ADDR_W-1:2], 2'b00};
                    htrans_d = TRANS_NONSEQ;
                    hburst_d = BURST_WRAP4;
                    busy_d   = 1'b1;
                    state_d  = ADDR;
                end
            end
            ADDR, DATA: begin
                if (hresp) begin
                    if (hready) begin
                        end_burst = 1'b1;
                        done_d    = 1'b1;
                        err_d     = 1'b1;
                    end else begin
                        htrans_d = TRANS_IDLE;
                        state_d  = ERR1;
                    end
                end else if (hready) begin
                    if (htrans_q != TRANS_IDLE) begin
                        acnt_d = acnt_q + 2'd1;
                        if (acnt_q == 2'd3) begin
                            htrans_d = TRANS_IDLE;
                            state_d  = DATA;
                        end else begin
                            htrans_d = TRANS_SEQ;
                            haddr_d  = next_addr;
                        end
                    end
                    dph_d = (htrans_q != TRANS_IDLE);
                    if (dph_q) begin
                        asm_d[dword] = hrdata;
                        dcnt_d       = dcnt_q + 2'd1;
                        if (dcnt_q == 2'd0) begin
                            cv_d = 1'b1;
                            cd_d = hrdata;
                        end
                        if (dcnt_q == 2'd3) begin
                            line_d    = asm_d;
                            done_d    = 1'b1;
                            end_burst = 1'b1;
                        end
                    end
                end
            end
            ERR1: begin
                if (hready) begin
                    end_burst = 1'b1;
                    done_d    = 1'b1;
                    err_d     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (end_burst) begin
            busy_d   = 1'b0;
            htrans_d = TRANS_IDLE;
            hburst_d = BURST_SINGLE;
            acnt_d   = 2'd0;
            dcnt_d   = 2'd0;
            dph_d    = 1'b0;
            state_d  = IDLE;
        end
    end

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            state_q  <= IDLE;
            acnt_q   <= 2'd0;
            dcnt_q   <= 2'd0;
            w0_q     <= 2'd0;
            base_q   <= '0;
            dph_q    <= 1'b0;
            asm_q    <= '0;
            line_q   <= '0;
            haddr_q  <= '0;
            htrans_q <= TRANS_IDLE;
            hburst_q <= BURST_SINGLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            cv_q     <= 1'b0;
            cd_q     <= '0;
        end else begin
            state_q  <= state_d;
            acnt_q   <= acnt_d;
            dcnt_q   <= dcnt_d;
            w0_q     <= w0_d;
            base_q   <= base_d;
            dph_q    <= dph_d;
            asm_q    <= asm_d;
            line_q   <= line_d;
            haddr_q  <= haddr_d;
            htrans_q <= htrans_d;
            hburst_q <= hburst_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            cv_q     <= cv_d;
            cd_q     <= cd_d;
        end
    end

    assign fill_busy  = busy_q;
    assign fill_done  = done_q;
    assign fill_err   = err_q;
    assign fill_line  = line_q;
    assign crit_valid = cv_q;
    assign crit_data  = cd_q;
    assign haddr      = haddr_q;
    assign htrans     = htrans_q;
    assign hburst     = hburst_q;
    assign hsize      = HSIZE_WORD;
    assign hwrite     = 1'b0;

endmodule
